// File: rtl/motor_sequencer.sv
// motor_sequencer: runs a timed forward/dwell/reverse/dwell program on each
// motor selected by a mask, with abort, pause and loop control. All outputs
// are registered so pads can connect directly.
module motor_sequencer #(
    parameter int N_MOTORS = 2,
    parameter int CNT_W    = 8,
    parameter int T_RUN    = 10,
    parameter int T_DWELL  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                en,
    input  logic [N_MOTORS-1:0] mask,
    input  logic                dir,
    input  logic                loop,
    output logic [N_MOTORS-1:0] motor_fwd,
    output logic [N_MOTORS-1:0] motor_rev,
    output logic [2:0]          motor_idx,
    output logic                busy,
    output logic                done,
    output logic                fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_A   = 3'd1,
        DWELL_A = 3'd2,
        RUN_B   = 3'd3,
        DWELL_B = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(T_RUN);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(T_DWELL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    timer, timer_next;
    logic [N_MOTORS-1:0] mask_q, mask_next;
    logic                dir_q, dir_next;
    logic [2:0]          idx, idx_next;

    logic [2:0]          start_idx, first_idx, next_idx;
    logic                has_next;
    logic                accept, empty_start, abort;

    logic [N_MOTORS-1:0] sel, fwd_next, rev_next;
    logic [2:0]          idx_out_next;
    logic                busy_next, done_next, fault_next, running;

    // Priority search: lowest bit of the incoming mask, lowest bit of the
    // latched mask, and the next latched bit above the current motor.
    always_comb begin
        start_idx = '0;
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = N_MOTORS - 1; i >= 0; i--) begin
            if (mask[i]) start_idx = 3'(i);
            if (mask_q[i]) first_idx = 3'(i);
            if (mask_q[i] && (i > int'(idx))) begin
                next_idx = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    // Next-state logic: stop aborts any active state, the phase timer only
    // advances on enabled cycles and reloads on every state entry.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        mask_next   = mask_q;
        dir_next    = dir_q;
        idx_next    = idx;
        accept      = 1'b0;
        empty_start = 1'b0;
        abort       = 1'b0;
        if ((state != IDLE) && stop) begin
            abort      = 1'b1;
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        accept    = 1'b1;
                        mask_next = mask;
                        dir_next  = dir;
                        idx_next  = start_idx;
                        if (mask == '0) begin
                            empty_start = 1'b1;
                        end else begin
                            state_next = RUN_A;
                            timer_next = RUN_LOAD;
                        end
                    end
                end
                RUN_A, RUN_B: begin
                    if (en) begin
                        if (timer <= CNT_ONE) begin
                            state_next = (state == RUN_A) ? DWELL_A : DWELL_B;
                            timer_next = DWELL_LOAD;
                        end else begin
                            timer_next = timer - CNT_ONE;
                        end
                    end
                end
                DWELL_A: begin
                    if (en) begin
                        if (timer <= CNT_ONE) begin
                            state_next = RUN_B;
                            timer_next = RUN_LOAD;
                        end else begin
                            timer_next = timer - CNT_ONE;
                        end
                    end
                end
                DWELL_B: begin
                    if (en) begin
                        if (timer <= CNT_ONE) begin
                            if (has_next) begin
                                idx_next   = next_idx;
                                state_next = RUN_A;
                                timer_next = RUN_LOAD;
                            end else if (loop) begin
                                idx_next   = first_idx;
                                state_next = RUN_A;
                                timer_next = RUN_LOAD;
                            end else begin
                                state_next = DONE;
                                timer_next = '0;
                            end
                        end else begin
                            timer_next = timer - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Sequencer state, phase timer and the program latched at start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            timer  <= '0;
            mask_q <= '0;
            dir_q  <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            mask_q <= mask_next;
            dir_q  <= dir_next;
            idx    <= idx_next;
        end
    end

    // Output values derived from the current state; drive is gated by en and
    // killed by stop on the same edge, so only one motor bit can be active.
    always_comb begin
        sel      = N_MOTORS'(1) << idx;
        fwd_next = '0;
        rev_next = '0;
        running  = (state == RUN_A) || (state == DWELL_A) ||
                   (state == RUN_B) || (state == DWELL_B);
        if ((state == RUN_A) && en && !stop) begin
            if (dir_q) rev_next = sel;
            else       fwd_next = sel;
        end
        if ((state == RUN_B) && en && !stop) begin
            if (dir_q) fwd_next = sel;
            else       rev_next = sel;
        end
        busy_next    = running && !stop;
        idx_out_next = busy_next ? idx : 3'd0;
        done_next    = done;
        fault_next   = fault;
        if (abort) begin
            fault_next = 1'b1;
            done_next  = 1'b0;
        end else if (accept) begin
            fault_next = empty_start;
            done_next  = 1'b0;
        end else if (state == DONE) begin
            done_next = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motor_fwd <= '0;
            motor_rev <= '0;
            motor_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            motor_fwd <= fwd_next;
            motor_rev <= rev_next;
            motor_idx <= idx_out_next;
            busy      <= busy_next;
            done      <= done_next;
            fault     <= fault_next;
        end
    end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Parametrised, fully synchronous motor/indicator sequencer for the motor-control datapath. It drives up to N_MOTORS bidirectional motors through a timed forward/dwell/reverse/dwell program per motor and produces status LED outputs. It replaces fixed two-motor state encodings and simulation-only `#` delay timers with cycle-counting timers. Motor-driver pads and LED pads connect directly to its registered outputs.

## Interface
- N_MOTORS, 2: number of motor channels (1..8).
- CNT_W, 8: timer counter width.
- T_RUN, 10: drive phase length in clock cycles (1..2^CNT_W-1).
- T_DWELL, 5: dead time between drive phases in cycles (1..2^CNT_W-1).
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  reset; asynchronous, active-low.
- start  in  1  level-sampled request; accepted only in IDLE.
- stop  in  1  abort; highest priority after reset.
- en  in  1  run enable; low freezes the timer and gates motor outputs.
- mask  in  N_MOTORS  motors to exercise; sampled with an accepted start.
- dir  in  1  0 = forward first, 1 = reverse first; sampled with start.
- loop  in  1  sampled at end of the last motor; 1 = restart program.
- motor_fwd  out  N_MOTORS  forward drive, one-hot or zero.
- motor_rev  out  N_MOTORS  reverse drive, one-hot or zero.
- motor_idx  out  3  index of the current motor (0 when idle).
- busy  out  1  program running.
- done  out  1  completion LED; holds until the next accepted start.
- fault  out  1  fault LED; holds until the next accepted start.

## Operation
- States: IDLE, RUN_A, DWELL_A, RUN_B, DWELL_B, DONE.
- IDLE with start=1 and stop=0:
  - mask, dir and motor_idx are latched.
  - done and fault clear.
  - If mask==0: fault=1, the block stays in IDLE and no motor is driven.
  - Otherwise, go to RUN_A with motor_idx = lowest set mask bit.
- RUN_A drives the dir-selected direction. RUN_B drives the opposite direction. Only bit motor_idx is driven.
- Each state lasts its programmed cycle count, counting only cycles with en=1:
  - RUN_A and RUN_B: T_RUN cycles.
  - DWELL_A and DWELL_B: T_DWELL cycles.
  - The timer reloads on every state entry.
- DWELL_B end:
  - If a higher set mask bit exists, advance motor_idx to it and go to RUN_A.
  - Else, if loop=1, go to RUN_A at the lowest set bit (done stays 0).
  - Else, go to DONE.
- DONE: done=1, busy=0. Returns to IDLE on the next cycle.
- stop=1 in any non-IDLE state:
  - Next state is IDLE and all drives go to 0 on that edge.
  - fault=1, done=0.
- stop=1 in IDLE: start is ignored and no fault is set.
- en=0:
  - motor_fwd and motor_rev are 0.
  - The timer and state hold.
  - stop still acts.
  - Drive resumes on the cycle after en returns to 1, with the remaining count intact.
- Interlocks, which hold in every state:
  - motor_fwd & motor_rev == 0.
  - At most one bit of motor_fwd|motor_rev is set.
  - Any direction reversal is separated by at least T_DWELL enabled cycles.
- Unset mask bits are skipped with zero cycles.
- motor_idx is zero-extended when N_MOTORS < 8.

## Timing
- Reset (asynchronous assertion, synchronous release): state=IDLE, timer=0, and every output is 0.
- All outputs are registered. No combinational path runs from any input to any output.
- Start latency: start is sampled at edge k, and drive is high from edge k+1.
- With en held high, motor i drive covers edges [k+1, k+T_RUN], dwell follows for T_DWELL cycles, then the opposite drive runs.
- One motor takes 2·(T_RUN+T_DWELL) cycles.
- For m motors selected, busy is high for m·2·(T_RUN+T_DWELL) cycles. done rises on the following edge.
- A stop sampled at edge j gives outputs zero and fault=1 after edge j.
- start and stop in the same cycle: stop wins, so there is no start and no fault in IDLE.

## Test plan
(Defaults N_MOTORS=2, T_RUN=10, T_DWELL=5, en=1; start sampled at edge 0.)
- Reset mid-run: assert reset low at cycle 7 of RUN_A -> all outputs 0 immediately (asynchronously); the block stays in IDLE after release.
- Full program, mask=2'b11, dir=0, loop=0:
  - motor_fwd=01 on edges 1–10, zeros on 11–15, motor_rev=01 on 16–25, zeros on 26–30.
  - Motor 1 repeats the pattern on edges 31–60.
  - done=1 from edge 61; busy=0.
- Reverse first with skip, mask=2'b10, dir=1 -> motor_rev=10 on edges 1–10, motor_fwd=10 on 16–25, done from edge 31; motor 0 is never driven.
- Abort and pause:
  - stop pulse at edge 18 (RUN_B, motor 0) -> outputs 0 from edge 18, fault=1, busy=0.
  - Separately, en=0 for 4 cycles during RUN_A -> drive low for those cycles; total RUN_A drive is still exactly 10 cycles.
- Loop and empty mask:
  - mask=2'b01 with loop=1 -> the 30-cycle pattern repeats with done=0 until stop.
  - mask=0 with start -> fault=1, busy=0, and no drive ever appears.
- Interlock check: a bench assertion on every cycle of all runs above confirms fwd&rev==0, popcount(fwd|rev)≤1, and a gap of at least 5 cycles between opposite drives.
